// File: rtl/fifo_stream_reader_if.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_reader_if
// Brief    : FIFO read-side and valid/ready stream signals of fifo_stream_reader.
//            master = the reader, slave = the FIFO plus downstream consumer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_stream_reader_if #(
   parameter int WIDTH = 16
);
   logic             fifo_empty;
   logic [WIDTH-1:0] fifo_q;
   logic             fifo_rdreq;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_last;
   logic             out_ready;

   modport master (
      input  fifo_empty, fifo_q, out_ready,
      output fifo_rdreq, out_valid, out_data, out_last
   );

   modport slave (
      output fifo_empty, fifo_q, out_ready,
      input  fifo_rdreq, out_valid, out_data, out_last
   );
endinterface

`default_nettype wire

// File: rtl/fifo_stream_reader.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_reader
// Brief    : Pops a show-ahead FIFO into a 2-entry skid buffer and presents
//            the words as a valid/ready stream, one word per cycle, with
//            out_last on every BURST_LEN-th delivered beat.
//            Optional macro FIFO_READER_STATS_EN adds the saturating
//            words_out / stall_cycles counters.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_stream_reader #(
   parameter int WIDTH     = 16,
   parameter int BURST_LEN = 4
) (
   input  wire logic            clock,
   input  wire logic            reset,
   input  wire logic            enable,
   fifo_stream_reader_if.master bus
`ifdef FIFO_READER_STATS_EN
   ,
   output logic [31:0]          words_out,
   output logic [31:0]          stall_cycles
`endif
);

   localparam int c_cntWidth = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam logic [c_cntWidth-1:0] c_lastBeat = c_cntWidth'(BURST_LEN - 1);

   // Buffer occupancy encoding
   localparam logic [1:0] c_stEmpty = 2'd0;
   localparam logic [1:0] c_stOne   = 2'd1;
   localparam logic [1:0] c_stTwo   = 2'd2;

   logic [1:0]            r_state;
   logic [1:0]            w_stateNext;
   logic [WIDTH-1:0]      r_entry0;
   logic [WIDTH-1:0]      r_entry1;
   logic [c_cntWidth-1:0] r_beatCnt;
   logic                  w_pop;
   logic                  w_valid;
   logic                  w_take;

   assign w_take = w_valid && bus.out_ready;

   // Occupancy state register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= c_stEmpty;
      else       r_state <= w_stateNext;
   end

   // Occupancy transitions from pop/take
   always_comb begin
      w_stateNext = r_state;
      case (r_state)
         c_stEmpty: if (w_pop) w_stateNext = c_stOne;
         c_stOne: begin
            if (w_pop && !w_take)      w_stateNext = c_stTwo;
            else if (!w_pop && w_take) w_stateNext = c_stEmpty;
         end
         c_stTwo:   if (w_take) w_stateNext = c_stOne;
         default:   w_stateNext = c_stEmpty;
      endcase
   end

   // Pop and valid decode from registered state only; the pop is also held off
   // during reset so a reset never consumes a FIFO word
   always_comb begin
      w_pop   = enable && !bus.fifo_empty && (r_state != c_stTwo) && !reset;
      w_valid = (r_state != c_stEmpty);
   end

   // Skid buffer: entry 0 is always the oldest word
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_entry0 <= '0;
         r_entry1 <= '0;
      end else begin
         case (r_state)
            c_stEmpty: if (w_pop) r_entry0 <= bus.fifo_q;
            c_stOne: begin
               if (w_pop && w_take)  r_entry0 <= bus.fifo_q;
               else if (w_pop)       r_entry1 <= bus.fifo_q;
            end
            c_stTwo:   if (w_take) r_entry0 <= r_entry1;
            default: ;
         endcase
      end
   end

   // Burst beat counter; only advances on delivered beats, so it survives enable gaps
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       r_beatCnt <= '0;
      else if (w_take) r_beatCnt <= (r_beatCnt == c_lastBeat) ? '0 : r_beatCnt + 1'b1;
   end

   assign bus.fifo_rdreq = w_pop;
   assign bus.out_valid  = w_valid;
   assign bus.out_data   = r_entry0;
   assign bus.out_last   = w_valid && (r_beatCnt == c_lastBeat);

`ifdef FIFO_READER_STATS_EN
   logic [31:0] r_wordsOut;
   logic [31:0] r_stallCycles;

   // Saturating delivered-word and stall-cycle counters
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_wordsOut    <= '0;
         r_stallCycles <= '0;
      end else begin
         if (w_take && (r_wordsOut != 32'hFFFF_FFFF))
            r_wordsOut <= r_wordsOut + 32'd1;
         if (w_valid && !bus.out_ready && (r_stallCycles != 32'hFFFF_FFFF))
            r_stallCycles <= r_stallCycles + 32'd1;
      end
   end

   assign words_out    = r_wordsOut;
   assign stall_cycles = r_stallCycles;
`endif

endmodule

`default_nettype wire
